// File: rtl/sram_like_arbiter.sv
// Arbiter sharing one sram-like master port between I and D requesters; D has priority,
// with a starvation guard for I. Optional grant statistics under `ARB_STATS_EN.
module sram_like_arbiter #(
   parameter int STARVE_LIMIT = 4,
   parameter int CNT_W        = 3
) (
   input  logic        clk,
   input  logic        rst,
`ifdef ARB_STATS_EN
   output logic [31:0] i_grant_cnt,
   output logic [31:0] d_grant_cnt,
   output logic [31:0] starve_hit_cnt,
`endif
   input  logic        i_req,
   input  logic        i_wr,
   input  logic [1:0]  i_size,
   input  logic [31:0] i_addr,
   input  logic [31:0] i_wdata,
   output logic        i_addr_ok,
   output logic        i_data_ok,
   output logic [31:0] i_rdata,
   input  logic        d_req,
   input  logic        d_wr,
   input  logic [1:0]  d_size,
   input  logic [31:0] d_addr,
   input  logic [31:0] d_wdata,
   input  logic [3:0]  d_wen,
   output logic        d_addr_ok,
   output logic        d_data_ok,
   output logic [31:0] d_rdata,
   output logic        m_req,
   output logic        m_wr,
   output logic [1:0]  m_size,
   output logic [31:0] m_addr,
   output logic [31:0] m_wdata,
   output logic [3:0]  m_wen,
   input  logic        m_addr_ok,
   input  logic        m_data_ok,
   input  logic [31:0] m_rdata
);

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_ADDR = 2'd1,
      ST_DATA = 2'd2
   } state_t;

   localparam logic [CNT_W-1:0] LIMIT = CNT_W'(STARVE_LIMIT);

   state_t           r_state;
   state_t           w_state_nxt;
   logic             r_owner_d;
   logic             r_wr;
   logic [1:0]       r_size;
   logic [31:0]      r_addr;
   logic [31:0]      r_wdata;
   logic [3:0]       r_wen;
   logic [CNT_W-1:0] r_starve_cnt;
   logic             w_starved;
   logic             w_grant_d;
   logic             w_grant_i;
   logic             w_done;

   // I is forced only when it is actually waiting and D has used up its run.
   assign w_starved = i_req && (r_starve_cnt == LIMIT);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) r_state <= ST_IDLE;
      else     r_state <= w_state_nxt;
   end

   always_comb begin
      w_state_nxt = r_state;
      w_grant_d   = 1'b0;
      w_grant_i   = 1'b0;
      w_done      = 1'b0;
      case (r_state)
         ST_IDLE: begin
            if (d_req && !w_starved) w_grant_d = 1'b1;
            else if (i_req)          w_grant_i = 1'b1;
            if (w_grant_d || w_grant_i) w_state_nxt = ST_ADDR;
         end
         // m_data_ok arriving with m_addr_ok is a downstream violation and is dropped.
         ST_ADDR: if (m_addr_ok) w_state_nxt = ST_DATA;
         ST_DATA: begin
            if (m_data_ok) begin
               w_done      = 1'b1;
               w_state_nxt = ST_IDLE;
            end
         end
         default: w_state_nxt = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_owner_d <= 1'b1;
         r_wr      <= 1'b0;
         r_size    <= 2'd0;
         r_addr    <= 32'd0;
         r_wdata   <= 32'd0;
         r_wen     <= 4'd0;
      end else if (w_grant_d) begin
         r_owner_d <= 1'b1;
         r_wr      <= d_wr;
         r_size    <= d_size;
         r_addr    <= d_addr;
         r_wdata   <= d_wdata;
         r_wen     <= d_wen;
      end else if (w_grant_i) begin
         r_owner_d <= 1'b0;
         r_wr      <= i_wr;
         r_size    <= i_size;
         r_addr    <= i_addr;
         r_wdata   <= i_wdata;
         r_wen     <= i_wr ? 4'b1111 : 4'b0000;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_starve_cnt <= '0;
      end else if (w_grant_d) begin
         if (!i_req)                    r_starve_cnt <= '0;
         else if (r_starve_cnt != LIMIT) r_starve_cnt <= r_starve_cnt + CNT_W'(1);
      end else if (w_grant_i) begin
         r_starve_cnt <= '0;
      end
   end

   // Handshake outputs are combinational, so gate them with rst to drop them at once.
   assign i_addr_ok = w_grant_i && !rst;
   assign d_addr_ok = w_grant_d && !rst;
   assign i_data_ok = w_done && !r_owner_d && !rst;
   assign d_data_ok = w_done &&  r_owner_d && !rst;
   assign i_rdata   = i_data_ok ? m_rdata : 32'd0;
   assign d_rdata   = d_data_ok ? m_rdata : 32'd0;

   assign m_req     = (r_state == ST_ADDR) && !rst;
   assign m_wr      = r_wr;
   assign m_size    = r_size;
   assign m_addr    = r_addr;
   assign m_wdata   = r_wdata;
   assign m_wen     = r_wen;

`ifdef ARB_STATS_EN
   logic [31:0] r_i_grant_cnt;
   logic [31:0] r_d_grant_cnt;
   logic [31:0] r_starve_hit_cnt;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_i_grant_cnt    <= 32'd0;
         r_d_grant_cnt    <= 32'd0;
         r_starve_hit_cnt <= 32'd0;
      end else begin
         if (w_grant_i) r_i_grant_cnt <= r_i_grant_cnt + 32'd1;
         if (w_grant_d) r_d_grant_cnt <= r_d_grant_cnt + 32'd1;
         // A competing D request means I only won through the guard.
         if (w_grant_i && d_req && w_starved) r_starve_hit_cnt <= r_starve_hit_cnt + 32'd1;
      end
   end

   assign i_grant_cnt    = r_i_grant_cnt;
   assign d_grant_cnt    = r_d_grant_cnt;
   assign starve_hit_cnt = r_starve_hit_cnt;
`endif

endmodule

// File: tb/tb_sram_like_arbiter.sv
// Bench for sram_like_arbiter: table of single-requester transactions plus hand-written
// priority, starvation, stall, reset and protocol-violation sequences; data via scoreboard.
module tb_sram_like_arbiter;

   logic        clk = 1'b0;
   logic        rst;
   logic        i_req, i_wr, d_req, d_wr;
   logic [1:0]  i_size, d_size;
   logic [31:0] i_addr, i_wdata, d_addr, d_wdata;
   logic [3:0]  d_wen;
   logic        i_addr_ok, i_data_ok, d_addr_ok, d_data_ok;
   logic [31:0] i_rdata, d_rdata;
   logic        m_req, m_wr, m_addr_ok, m_data_ok;
   logic [1:0]  m_size;
   logic [31:0] m_addr, m_wdata, m_rdata;
   logic [3:0]  m_wen;
`ifdef ARB_STATS_EN
   logic [31:0] i_grant_cnt, d_grant_cnt, starve_hit_cnt;
`endif

   sram_like_arbiter #(.STARVE_LIMIT(4), .CNT_W(3)) dut (
      .clk(clk), .rst(rst),
`ifdef ARB_STATS_EN
      .i_grant_cnt(i_grant_cnt), .d_grant_cnt(d_grant_cnt), .starve_hit_cnt(starve_hit_cnt),
`endif
      .i_req(i_req), .i_wr(i_wr), .i_size(i_size), .i_addr(i_addr), .i_wdata(i_wdata),
      .i_addr_ok(i_addr_ok), .i_data_ok(i_data_ok), .i_rdata(i_rdata),
      .d_req(d_req), .d_wr(d_wr), .d_size(d_size), .d_addr(d_addr), .d_wdata(d_wdata),
      .d_wen(d_wen), .d_addr_ok(d_addr_ok), .d_data_ok(d_data_ok), .d_rdata(d_rdata),
      .m_req(m_req), .m_wr(m_wr), .m_size(m_size), .m_addr(m_addr), .m_wdata(m_wdata),
      .m_wen(m_wen), .m_addr_ok(m_addr_ok), .m_data_ok(m_data_ok), .m_rdata(m_rdata)
   );

   always #5 clk = ~clk;

   typedef struct {
      bit          is_d;
      bit          wr;
      logic [1:0]  size;
      logic [31:0] addr;
      logic [31:0] wdata;
      logic [3:0]  wen;
      logic [31:0] rdata;
      int          aw;
      logic [3:0]  exp_wen;
   } vec_t;

   typedef struct packed {
      logic        owner_d;
      logic [31:0] rdata;
   } sb_t;

   sb_t  sb[$];
   sb_t  mon_e;
   int   n_pass = 0;
   int   n_tot  = 0;
   vec_t tbl[5];

   function automatic void chk(string nm, logic [31:0] act, logic [31:0] exp);
      n_tot++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got 0x%08h, expected 0x%08h (t=%0t)", nm, act, exp, $time);
   endfunction

   function automatic vec_t mk(bit d, bit wr, logic [1:0] sz, logic [31:0] a, logic [31:0] wd,
                               logic [3:0] wen, logic [31:0] rd, int aw, logic [3:0] ew);
      vec_t v;
      v.is_d = d; v.wr = wr; v.size = sz; v.addr = a; v.wdata = wd;
      v.wen = wen; v.rdata = rd; v.aw = aw; v.exp_wen = ew;
      return v;
   endfunction

   // Scoreboard: every data_ok must match the oldest outstanding expectation.
   always @(negedge clk) begin
      if (i_data_ok || d_data_ok) begin
         if (sb.size() == 0) begin
            n_tot++;
            $display("FAIL sb_unexpected: i_data_ok=%0b d_data_ok=%0b, expected none (t=%0t)",
                     i_data_ok, d_data_ok, $time);
         end else begin
            mon_e = sb.pop_front();
            chk("sb_owner_d", 32'(d_data_ok), 32'(mon_e.owner_d));
            chk("sb_both_ok", 32'(i_data_ok & d_data_ok), 0);
            chk("sb_rdata", mon_e.owner_d ? d_rdata : i_rdata, mon_e.rdata);
            chk("sb_other_rdata", mon_e.owner_d ? i_rdata : d_rdata, 0);
         end
      end
   end

   task automatic clear_inputs();
      i_req = 0; i_wr = 0; i_size = 0; i_addr = 0; i_wdata = 0;
      d_req = 0; d_wr = 0; d_size = 0; d_addr = 0; d_wdata = 0; d_wen = 0;
      m_addr_ok = 0; m_data_ok = 0; m_rdata = 0;
   endtask

   task automatic do_reset();
      rst = 1'b1;
      clear_inputs();
      @(posedge clk); #1;
      rst = 1'b0;
   endtask

   task automatic drive(input vec_t v);
      if (v.is_d) begin
         d_req = 1; d_wr = v.wr; d_size = v.size; d_addr = v.addr; d_wdata = v.wdata; d_wen = v.wen;
      end else begin
         i_req = 1; i_wr = v.wr; i_size = v.size; i_addr = v.addr; i_wdata = v.wdata;
      end
   endtask

   task automatic chk_fields(input vec_t v);
      chk("m_req", 32'(m_req), 1);
      chk("m_wr", 32'(m_wr), 32'(v.wr));
      chk("m_size", 32'(m_size), 32'(v.size));
      chk("m_addr", m_addr, v.addr);
      chk("m_wdata", m_wdata, v.wdata);
      chk("m_wen", 32'(m_wen), 32'(v.exp_wen));
   endtask

   // Called at posedge+1 in IDLE with requests already driven; v is the expected winner.
   task automatic run_txn(input vec_t v);
      sb_t e;
      @(negedge clk);
      chk("addr_ok_owner", 32'(v.is_d ? d_addr_ok : i_addr_ok), 1);
      chk("addr_ok_other", 32'(v.is_d ? i_addr_ok : d_addr_ok), 0);
      chk("m_req_idle", 32'(m_req), 0);
      e.owner_d = v.is_d; e.rdata = v.rdata;
      sb.push_back(e);
      @(posedge clk); #1;
      if (v.is_d) d_req = 0; else i_req = 0;
      m_addr_ok = 0;
      for (int k = 0; k < v.aw; k++) begin
         @(negedge clk);
         chk_fields(v);
         chk("busy_addr_ok", 32'({i_addr_ok, d_addr_ok}), 0);
         @(posedge clk); #1;
      end
      m_addr_ok = 1;
      @(negedge clk);
      chk_fields(v);
      chk("busy_addr_ok", 32'({i_addr_ok, d_addr_ok}), 0);
      @(posedge clk); #1;
      m_addr_ok = 0; m_data_ok = 1; m_rdata = v.rdata;
      @(negedge clk);
      chk("m_req_data", 32'(m_req), 0);
      chk("data_addr_ok", 32'({i_addr_ok, d_addr_ok}), 0);
      @(posedge clk); #1;
      m_data_ok = 0; m_rdata = 0;
      chk("sb_drained", 32'(sb.size()), 0);
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   initial begin
      vec_t vi, vd, vw;
      sb_t  e;
      // is_d wr size addr wdata wen rdata addr_wait exp_m_wen
      tbl[0] = mk(0, 0, 2'd2, 32'h1FC00000, 32'h0,        4'h0, 32'hDEADBEEF, 0, 4'b0000);
      tbl[1] = mk(1, 1, 2'd2, 32'h80001000, 32'h11223344, 4'hF, 32'h0,        1, 4'b1111);
      tbl[2] = mk(1, 0, 2'd0, 32'h00000003, 32'h0,        4'h0, 32'hA5A5A5A5, 2, 4'b0000);
      tbl[3] = mk(0, 1, 2'd2, 32'h1FC00010, 32'hCAFEF00D, 4'h0, 32'h0,        0, 4'b1111);
      tbl[4] = mk(1, 1, 2'd1, 32'h00000102, 32'h0000BEEF, 4'hC, 32'h0,        0, 4'b1100);

      // Reset state
      rst = 1'b1;
      clear_inputs();
      @(negedge clk);
      chk("rst_i_addr_ok", 32'(i_addr_ok), 0);
      chk("rst_d_addr_ok", 32'(d_addr_ok), 0);
      chk("rst_i_data_ok", 32'(i_data_ok), 0);
      chk("rst_d_data_ok", 32'(d_data_ok), 0);
      chk("rst_i_rdata", i_rdata, 0);
      chk("rst_d_rdata", d_rdata, 0);
      chk("rst_m_req", 32'(m_req), 0);
      chk("rst_m_wr", 32'(m_wr), 0);
      chk("rst_m_size", 32'(m_size), 0);
      chk("rst_m_addr", m_addr, 0);
      chk("rst_m_wdata", m_wdata, 0);
      chk("rst_m_wen", 32'(m_wen), 0);
      @(posedge clk); #1;
      rst = 1'b0;

      // Table: single-requester transactions (entry 0 is the minimum-latency I read)
      for (int t = 0; t < 5; t++) begin
         drive(tbl[t]);
         run_txn(tbl[t]);
      end

      // Simultaneous requests from reset: D first, then I
      do_reset();
      vd = mk(1, 1, 2'd2, 32'h80001000, 32'h0BADF00D, 4'b0011, 32'h0, 0, 4'b0011);
      vi = mk(0, 0, 2'd2, 32'h1FC00020, 32'h0, 4'h0, 32'h12345678, 0, 4'b0000);
      drive(vi); drive(vd);
      run_txn(vd);
      run_txn(vi);

      // Starvation guard: D,D,D,D,I,D with I held
      do_reset();
      for (int k = 0; k < 6; k++) begin
         vd = mk(1, 0, 2'd2, 32'h80002000 + 32'(k * 4), 32'h0, 4'h0, 32'hD0000000 + 32'(k), 0, 4'h0);
         vi = mk(0, 0, 2'd2, 32'h1FC00100, 32'h0, 4'h0, 32'h11110000 + 32'(k), 0, 4'h0);
         drive(vi); drive(vd);
         run_txn((k == 4) ? vi : vd);
      end
      i_req = 0; d_req = 0;
`ifdef ARB_STATS_EN
      chk("stat_d_after_starve", d_grant_cnt, 5);
      chk("stat_i_after_starve", i_grant_cnt, 1);
      chk("stat_starve_hit", starve_hit_cnt, 1);
`endif

      // Downstream stalls m_addr_ok for 5 cycles while I waits
      do_reset();
      vw = mk(1, 1, 2'd2, 32'h80003000, 32'h55AA55AA, 4'b1010, 32'h0, 5, 4'b1010);
      vi = mk(0, 0, 2'd2, 32'h1FC00200, 32'h0, 4'h0, 32'h0F0F0F0F, 0, 4'h0);
      drive(vi); drive(vw);
      run_txn(vw);
      run_txn(vi);

      // m_data_ok in IDLE is ignored
      m_data_ok = 1; m_rdata = 32'hBADBAD00;
      @(negedge clk);
      chk("idle_data_ok", 32'({i_data_ok, d_data_ok}), 0);
      @(posedge clk); #1;
      m_data_ok = 0; m_rdata = 0;

      // m_addr_ok with m_data_ok in ADDR: data_ok ignored, wait for a real one in DATA
      vi = mk(0, 0, 2'd2, 32'h00000100, 32'h0, 4'h0, 32'h13579BDF, 0, 4'h0);
      drive(vi);
      @(negedge clk);
      chk("pv_addr_ok", 32'(i_addr_ok), 1);
      e.owner_d = 1'b0; e.rdata = 32'h13579BDF;
      sb.push_back(e);
      @(posedge clk); #1;
      i_req = 0; m_addr_ok = 1; m_data_ok = 1; m_rdata = 32'hBAD0BAD0;
      @(negedge clk);
      chk("pv_m_req", 32'(m_req), 1);
      chk("pv_no_data_ok", 32'(i_data_ok), 0);
      @(posedge clk); #1;
      m_addr_ok = 0; m_data_ok = 0; m_rdata = 0;
      @(negedge clk);
      chk("pv_in_data", 32'(m_req), 0);
      chk("pv_wait_data_ok", 32'(i_data_ok), 0);
      @(posedge clk); #1;
      m_data_ok = 1; m_rdata = 32'h13579BDF;
      @(posedge clk); #1;
      m_data_ok = 0; m_rdata = 0;
      chk("pv_sb_drained", 32'(sb.size()), 0);

      // Reset asserted during DATA drops the transaction
      vi = mk(0, 0, 2'd2, 32'h1FC00300, 32'h0, 4'h0, 32'h0, 0, 4'h0);
      drive(vi);
      @(negedge clk);
      chk("rd_addr_ok", 32'(i_addr_ok), 1);
      @(posedge clk); #1;
      i_req = 0; m_addr_ok = 1;
      @(posedge clk); #1;
      m_addr_ok = 0;
      rst = 1; m_data_ok = 1; m_rdata = 32'hFFFF0000;
      @(negedge clk);
      chk("rd_m_req", 32'(m_req), 0);
      chk("rd_data_ok", 32'({i_data_ok, d_data_ok}), 0);
      chk("rd_i_rdata", i_rdata, 0);
      @(posedge clk); #1;
      rst = 0;
      @(negedge clk);
      chk("rd_post_m_req", 32'(m_req), 0);
      chk("rd_post_data_ok", 32'({i_data_ok, d_data_ok}), 0);
      @(posedge clk); #1;
      m_data_ok = 0; m_rdata = 0;
      vi = mk(0, 0, 2'd2, 32'h1FC00400, 32'h0, 4'h0, 32'h600DF00D, 1, 4'h0);
      drive(vi);
      run_txn(vi);

`ifdef ARB_STATS_EN
      do_reset();
      for (int k = 0; k < 5; k++) begin
         vw = mk(k < 3, 0, 2'd2, 32'h00004000 + 32'(k * 4), 32'h0, 4'h0, 32'h0, 0, 4'h0);
         drive(vw);
         run_txn(vw);
      end
      chk("stat_d_grants", d_grant_cnt, 3);
      chk("stat_i_grants", i_grant_cnt, 2);
      chk("stat_no_starve", starve_hit_cnt, 0);
`endif

      chk("final_sb_empty", 32'(sb.size()), 0);
      $display("%0d/%0d checks passed", n_pass, n_tot);
      $finish;
   end

endmodule
